rs_age_issue: RTL and testbench
===============================

# rs_age_issue

Parametrised reservation station for the out-of-order core: holds up to 2^RS_BITS renamed ALU micro-ops, wakes operands from NUM_CDB result broadcast ports and dispatches one ready entry per cycle to the ALU over a valid/ready handshake. Among ready entries the oldest wins, with age measured as RoB distance from the current RoB head. It sits between the issue stage (operands already read from the register file / RoB) and the ALU, and is flushed by the RoB on misprediction.

## Interface
- RS_BITS, 3, log2 of entry count (SIZE = 2^RS_BITS, RS_BITS ≥ 1)
- ROB_BITS, 4, RoB tag width
- NUM_CDB, 2, number of result broadcast ports (≥ 1)
- XLEN, 32, operand width
- OP_W, 6, opcode field width (passed through opaquely)

- clk_in  in  1  system clock; all state on rising edge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  low = stall: state frozen, no issue/dispatch
- clear_in  in  1  synchronous flush from RoB
- rob_head  in  ROB_BITS  tag of oldest in-flight RoB entry
- issue_valid  in  1  new micro-op offered
- issue_ready  out  1  entry free and rdy_in high
- issue_op  in  OP_W
- issue_dest  in  ROB_BITS  destination RoB tag
- issue_vj / issue_vk  in  XLEN  operand values (meaningful when ready bit set)
- issue_qj / issue_qk  in  ROB_BITS  producer tags (meaningful when ready bit clear)
- issue_rdj / issue_rdk  in  1  operand already available
- issue_imm  in  XLEN
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_id  in  NUM_CDB*ROB_BITS  port p at bits [p*ROB_BITS +: ROB_BITS]
- cdb_value  in  NUM_CDB*XLEN  port p at bits [p*XLEN +: XLEN]
- disp_valid  out  1  selected entry presented
- disp_ready  in  1  ALU accepts
- disp_op, disp_vj, disp_vk, disp_imm, disp_dest  out  OP_W/XLEN/XLEN/XLEN/ROB_BITS  selected entry fields
- count  out  RS_BITS+1  occupied entries
- full / empty  out  1  count == SIZE / count == 0

## Operation
- Entry state: busy, op, vj, vk, qj, qk, rdj, rdk, imm, dest. Entry is *ready* when busy && rdj && rdk.
- Issue: on issue_valid && issue_ready, write the lowest-index free entry. For each operand with ready bit clear, if any cdb_valid[p] && cdb_id[p] == q in the same cycle, capture cdb_value[p] and store ready=1 (issue-time bypass).
- Wakeup: every cycle, every busy entry with rdj==0 and qj matching a valid CDB port captures the value and sets rdj; same for k. Multiple matching ports: lowest p wins.
- Select (combinational): among ready entries, minimum age = (dest − rob_head) mod 2^ROB_BITS; ties to lower index. disp_* show the selected entry; all disp_* data outputs are 0 when disp_valid=0.
- Dispatch: disp_valid && disp_ready frees the selected entry at the clock edge.
- count: +1 on issue, −1 on dispatch, unchanged when both or neither.
- rdy_in=0: no state update (issue, wakeup, dispatch all suppressed); issue_ready=0, disp_valid=0. CDB events during stall are lost (producer holds its broadcast under the same stall).
- clear_in=1 (with rdy_in high or low): all entries freed next edge; concurrent issue/dispatch/wakeup discarded.

## Timing
- Reset (async, immediate): all busy=0, count=0, empty=1, full=0, disp_valid=0, disp_* data=0; issue_ready=1 once rst_in falls and rdy_in=1.
- issue_ready = rdy_in && !full; it does not account for a same-cycle dispatch (issue into a full RS is refused even if one entry leaves).
- Entry issued at edge N with both operands ready (or bypassed): disp_valid earliest in cycle N+1.
- CDB match in cycle N: entry may dispatch in cycle N+1 (no same-cycle CDB→dispatch forwarding).
- disp_valid may deassert without disp_ready (selection changes on clear, stall, older entry becoming ready); the ALU samples only on handshake.
- Wrap-around: age arithmetic is modulo 2^ROB_BITS; dests behind rob_head never occur.

## Test plan
- Reset mid-operation: fill 3 entries, assert rst_in asynchronously between edges -> count=0, empty=1, disp_valid=0 immediately, no entry dispatched after release.
- Fill/full: 8 issues with rdj=rdk=1, disp_ready=0 -> count=8, full=1, issue_ready=0; one handshake -> count=7, issue_ready=1 next cycle.
- Oldest-first with wrap: rob_head=14, issue dests 1,15,14 all ready, disp_ready=1 -> dispatch order 14,15,1.
- Dual-CDB wakeup: entry qj=5, qk=6 not ready; cycle N cdb0={5,0xAAAA0000}, cdb1={6,0x0000BBBB} -> disp_valid in N+1 with vj=0xAAAA0000, vk=0x0000BBBB.
- Issue bypass: issue qj=3 rdj=0 while cdb1={3,0x12345678} -> dispatched next cycle with vj=0x12345678.
- Flush/stall: 4 busy entries, rdy_in=0 with CDB activity -> no change; clear_in=1 -> count=0 next edge, simultaneous issue dropped.

Source files
------------

// File: rtl/rs_age_issue.sv
// Reservation station for ALU micro-ops. Entries wait for their operands,
// capture results broadcast on the CDB ports, and the oldest ready entry
// (smallest RoB distance from rob_head) is offered to the ALU each cycle.
module rs_age_issue #(
  parameter int RS_BITS  = 3,
  parameter int ROB_BITS = 4,
  parameter int NUM_CDB  = 2,
  parameter int XLEN     = 32,
  parameter int OP_W     = 6
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear_in,
  input  logic [ROB_BITS-1:0]          rob_head,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [OP_W-1:0]              issue_op,
  input  logic [ROB_BITS-1:0]          issue_dest,
  input  logic [XLEN-1:0]              issue_vj,
  input  logic [XLEN-1:0]              issue_vk,
  input  logic [ROB_BITS-1:0]          issue_qj,
  input  logic [ROB_BITS-1:0]          issue_qk,
  input  logic                         issue_rdj,
  input  logic                         issue_rdk,
  input  logic [XLEN-1:0]              issue_imm,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_BITS-1:0]  cdb_id,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [OP_W-1:0]              disp_op,
  output logic [XLEN-1:0]              disp_vj,
  output logic [XLEN-1:0]              disp_vk,
  output logic [XLEN-1:0]              disp_imm,
  output logic [ROB_BITS-1:0]          disp_dest,
  output logic [RS_BITS:0]             count,
  output logic                         full,
  output logic                         empty
);

  localparam int SIZE = 1 << RS_BITS;
  localparam logic [RS_BITS:0] FULL_COUNT = SIZE[RS_BITS:0];
  localparam logic [RS_BITS:0] CNT_ONE    = {{RS_BITS{1'b0}}, 1'b1};

  // Returns {hit, value}; the lowest-numbered matching port wins.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_BITS-1:0]         tag,
    input logic [NUM_CDB-1:0]          valid,
    input logic [NUM_CDB*ROB_BITS-1:0] ids,
    input logic [NUM_CDB*XLEN-1:0]     values
  );
    logic [XLEN:0] result;
    result = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      result = (valid[p] && (ids[p*ROB_BITS +: ROB_BITS] == tag)) ?
               {1'b1, values[p*XLEN +: XLEN]} : result;
    end
    return result;
  endfunction

  // RoB distance from the head; modulo arithmetic handles tag wrap.
  function automatic logic [ROB_BITS-1:0] rob_age(
    input logic [ROB_BITS-1:0] dest,
    input logic [ROB_BITS-1:0] head
  );
    return dest - head;
  endfunction

  logic                busy_r [SIZE];
  logic [OP_W-1:0]     op_r   [SIZE];
  logic [XLEN-1:0]     vj_r   [SIZE];
  logic [XLEN-1:0]     vk_r   [SIZE];
  logic [ROB_BITS-1:0] qj_r   [SIZE];
  logic [ROB_BITS-1:0] qk_r   [SIZE];
  logic                rdj_r  [SIZE];
  logic                rdk_r  [SIZE];
  logic [XLEN-1:0]     imm_r  [SIZE];
  logic [ROB_BITS-1:0] dest_r [SIZE];
  logic [RS_BITS:0]    count_r;

  logic [XLEN:0]       wake_j_s [SIZE];
  logic [XLEN:0]       wake_k_s [SIZE];
  logic [XLEN:0]       byp_j_s;
  logic [XLEN:0]       byp_k_s;
  logic                free_found_s;
  logic [RS_BITS-1:0]  free_idx_s;
  logic                sel_found_s;
  logic [RS_BITS-1:0]  sel_idx_s;
  logic [ROB_BITS-1:0] best_age_s;
  logic                better_s;
  logic                do_issue_s;
  logic                do_disp_s;

  assign count       = count_r;
  assign full        = (count_r == FULL_COUNT);
  assign empty       = (count_r == '0);
  assign issue_ready = rdy_in && !full;
  assign disp_valid  = rdy_in && sel_found_s;
  assign do_issue_s  = issue_valid && issue_ready;
  assign do_disp_s   = disp_valid && disp_ready;
  assign byp_j_s     = cdb_lookup(issue_qj, cdb_valid, cdb_id, cdb_value);
  assign byp_k_s     = cdb_lookup(issue_qk, cdb_valid, cdb_id, cdb_value);

  // Per-entry CDB match for both operands.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      wake_j_s[i] = cdb_lookup(qj_r[i], cdb_valid, cdb_id, cdb_value);
      wake_k_s[i] = cdb_lookup(qk_r[i], cdb_valid, cdb_id, cdb_value);
    end
  end

  // Lowest-index free slot receives the next issued micro-op.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = 0; i < SIZE; i++) begin
      free_idx_s   = (!busy_r[i] && !free_found_s) ? i[RS_BITS-1:0] : free_idx_s;
      free_found_s = free_found_s | !busy_r[i];
    end
  end

  // Oldest ready entry; strict compare in ascending order keeps ties on the lower index.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    best_age_s  = '0;
    better_s    = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      better_s    = busy_r[i] && rdj_r[i] && rdk_r[i] &&
                    (!sel_found_s || (rob_age(dest_r[i], rob_head) < best_age_s));
      sel_idx_s   = better_s ? i[RS_BITS-1:0] : sel_idx_s;
      best_age_s  = better_s ? rob_age(dest_r[i], rob_head) : best_age_s;
      sel_found_s = sel_found_s | better_s;
    end
  end

  // Dispatch bus shows the selected entry, zero when nothing is offered.
  always_comb begin
    disp_op   = '0;
    disp_vj   = '0;
    disp_vk   = '0;
    disp_imm  = '0;
    disp_dest = '0;
    if (disp_valid) begin
      disp_op   = op_r[sel_idx_s];
      disp_vj   = vj_r[sel_idx_s];
      disp_vk   = vk_r[sel_idx_s];
      disp_imm  = imm_r[sel_idx_s];
      disp_dest = dest_r[sel_idx_s];
    end else begin
      disp_op   = '0;
      disp_vj   = '0;
      disp_vk   = '0;
      disp_imm  = '0;
      disp_dest = '0;
    end
  end

  // Entry state: flush, then wakeup, dispatch release and issue write under rdy_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_r <= '0;
      for (int i = 0; i < SIZE; i++) begin
        busy_r[i] <= 1'b0;
        op_r[i]   <= '0;
        vj_r[i]   <= '0;
        vk_r[i]   <= '0;
        qj_r[i]   <= '0;
        qk_r[i]   <= '0;
        rdj_r[i]  <= 1'b0;
        rdk_r[i]  <= 1'b0;
        imm_r[i]  <= '0;
        dest_r[i] <= '0;
      end
    end else if (clear_in) begin
      count_r <= '0;
      for (int i = 0; i < SIZE; i++) begin
        busy_r[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < SIZE; i++) begin
        if (busy_r[i] && !rdj_r[i] && wake_j_s[i][XLEN]) begin
          rdj_r[i] <= 1'b1;
          vj_r[i]  <= wake_j_s[i][XLEN-1:0];
        end
        if (busy_r[i] && !rdk_r[i] && wake_k_s[i][XLEN]) begin
          rdk_r[i] <= 1'b1;
          vk_r[i]  <= wake_k_s[i][XLEN-1:0];
        end
      end
      if (do_disp_s) begin
        busy_r[sel_idx_s] <= 1'b0;
      end
      if (do_issue_s) begin
        busy_r[free_idx_s] <= 1'b1;
        op_r[free_idx_s]   <= issue_op;
        imm_r[free_idx_s]  <= issue_imm;
        dest_r[free_idx_s] <= issue_dest;
        qj_r[free_idx_s]   <= issue_qj;
        qk_r[free_idx_s]   <= issue_qk;
        rdj_r[free_idx_s]  <= issue_rdj | byp_j_s[XLEN];
        rdk_r[free_idx_s]  <= issue_rdk | byp_k_s[XLEN];
        vj_r[free_idx_s]   <= (!issue_rdj && byp_j_s[XLEN]) ? byp_j_s[XLEN-1:0] : issue_vj;
        vk_r[free_idx_s]   <= (!issue_rdk && byp_k_s[XLEN]) ? byp_k_s[XLEN-1:0] : issue_vk;
      end
      case ({do_issue_s, do_disp_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_age_issue.sv
// Self-checking bench for rs_age_issue: directed scenarios plus a randomized
// run compared against a queue-based model of the reservation station.
module tb_rs_age_issue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic [3:0]  rob_head = 4'd0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [5:0]  issue_op = 6'd0;
  logic [3:0]  issue_dest = 4'd0;
  logic [31:0] issue_vj = 32'd0;
  logic [31:0] issue_vk = 32'd0;
  logic [3:0]  issue_qj = 4'd0;
  logic [3:0]  issue_qk = 4'd0;
  logic        issue_rdj = 1'b0;
  logic        issue_rdk = 1'b0;
  logic [31:0] issue_imm = 32'd0;
  logic [1:0]  cdb_valid = 2'b00;
  logic [3:0]  cid0 = 4'd0, cid1 = 4'd0;
  logic [31:0] cval0 = 32'd0, cval1 = 32'd0;
  logic [7:0]  cdb_id;
  logic [63:0] cdb_value;
  logic        disp_valid;
  logic        disp_ready = 1'b0;
  logic [5:0]  disp_op;
  logic [31:0] disp_vj, disp_vk, disp_imm;
  logic [3:0]  disp_dest;
  logic [3:0]  count;
  logic        full, empty;

  int checks = 0;
  int failures = 0;

  assign cdb_id    = {cid1, cid0};
  assign cdb_value = {cval1, cval0};

  always #5 clk_in = ~clk_in;

  rs_age_issue #(.RS_BITS(3), .ROB_BITS(4), .NUM_CDB(2), .XLEN(32), .OP_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .rob_head(rob_head), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dest(issue_dest), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rdj(issue_rdj), .issue_rdk(issue_rdk),
    .issue_imm(issue_imm), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_vj(disp_vj),
    .disp_vk(disp_vk), .disp_imm(disp_imm), .disp_dest(disp_dest), .count(count),
    .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  dest;
    logic [3:0]  qj;
    logic [3:0]  qk;
    logic        rdj;
    logic        rdk;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
  } ent_t;

  ent_t mq[$];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] dest, input logic [3:0] qj, input logic [3:0] qk,
                           input logic rdj, input logic rdk, input logic [31:0] vj,
                           input logic [31:0] vk);
    issue_valid = 1'b1;
    issue_dest  = dest;
    issue_op    = {2'b00, dest};
    issue_qj    = qj;
    issue_qk    = qk;
    issue_rdj   = rdj;
    issue_rdk   = rdk;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_imm   = {28'd0, dest} + 32'd1000;
  endtask

  function automatic bit tag_in_use(input logic [3:0] tag);
    foreach (mq[i]) if (mq[i].dest == tag) return 1'b1;
    return 1'b0;
  endfunction

  // First valid port carrying the tag supplies the value.
  function automatic bit model_cdb(input logic [3:0] tag, output logic [31:0] val);
    val = 32'd0;
    if (cdb_valid[0] && cid0 == tag) begin val = cval0; return 1'b1; end
    if (cdb_valid[1] && cid1 == tag) begin val = cval1; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", empty, full); end
    checks++; if (disp_valid !== 1'b0 || disp_vj !== 32'd0 || disp_dest !== 4'd0) begin failures++; $display("FAIL reset_disp got valid=%0b vj=%0h dest=%0d exp 0", disp_valid, disp_vj, disp_dest); end
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready); end
  endtask

  task automatic test_fill_full();
    rob_head = 4'd0; disp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_issue(i[3:0], 4'd0, 4'd0, 1'b1, 1'b1, 32'd100 + i, 32'd200 + i);
      tick();
    end
    issue_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL full_count got count=%0d full=%0b exp 8/1", count, full); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL full_issue_ready got=%0b exp=0", issue_ready); end
    checks++; if (disp_valid !== 1'b1 || disp_dest !== 4'd0 || disp_vj !== 32'd100) begin failures++; $display("FAIL full_oldest got v=%0b dest=%0d vj=%0d exp 1/0/100", disp_valid, disp_dest, disp_vj); end
    // Issue offered while full and one entry leaves: issue is still refused.
    set_issue(4'd8, 4'd0, 4'd0, 1'b1, 1'b1, 32'd1, 32'd2);
    disp_ready = 1'b1;
    tick();
    issue_valid = 1'b0; disp_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd7 || full !== 1'b0) begin failures++; $display("FAIL full_handshake got count=%0d full=%0b exp 7/0", count, full); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL full_ready_again got=%0b exp=1", issue_ready); end
    checks++; if (disp_dest !== 4'd1 || disp_imm !== 32'd1001) begin failures++; $display("FAIL full_next got dest=%0d imm=%0d exp 1/1001", disp_dest, disp_imm); end
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL full_clear got count=%0d empty=%0b exp 0/1", count, empty); end
  endtask

  task automatic test_reset_mid();
    disp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(i[3:0], 4'd0, 4'd0, 1'b1, 1'b1, 32'd7, 32'd8);
      tick();
    end
    issue_valid = 1'b0;
    #3;
    rst_in = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL midreset_count got count=%0d empty=%0b exp 0/1", count, empty); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL midreset_disp got=%0b exp=0", disp_valid); end
    @(posedge clk_in); #1;
    rst_in = 1'b0; disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (disp_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL midreset_release got valid=%0b count=%0d exp 0/0", disp_valid, count); end
      tick();
    end
    disp_ready = 1'b0;
  endtask

  task automatic test_wrap_order();
    logic [3:0] order [3];
    order[0] = 4'd14; order[1] = 4'd15; order[2] = 4'd1;
    rob_head = 4'd14; disp_ready = 1'b0;
    set_issue(4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'd11, 32'd0); tick();
    set_issue(4'd15, 4'd0, 4'd0, 1'b1, 1'b1, 32'd25, 32'd0); tick();
    set_issue(4'd14, 4'd0, 4'd0, 1'b1, 1'b1, 32'd24, 32'd0); tick();
    issue_valid = 1'b0; disp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (disp_valid !== 1'b1 || disp_dest !== order[k]) begin failures++; $display("FAIL wrap_order[%0d] got valid=%0b dest=%0d exp 1/%0d", k, disp_valid, disp_dest, order[k]); end
      tick();
    end
    disp_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
    rob_head = 4'd0;
  endtask

  task automatic test_dual_cdb();
    disp_ready = 1'b0;
    set_issue(4'd2, 4'd5, 4'd6, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL cdb_waiting got=%0b exp=0", disp_valid); end
    cdb_valid = 2'b11; cid0 = 4'd5; cval0 = 32'hAAAA0000; cid1 = 4'd6; cval1 = 32'h0000BBBB;
    #1;
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL cdb_same_cycle got=%0b exp=0", disp_valid); end
    tick();
    cdb_valid = 2'b00;
    #1;
    checks++; if (disp_valid !== 1'b1 || disp_vj !== 32'hAAAA0000 || disp_vk !== 32'h0000BBBB) begin failures++; $display("FAIL cdb_wakeup got valid=%0b vj=%0h vk=%0h exp 1/aaaa0000/bbbb", disp_valid, disp_vj, disp_vk); end
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL cdb_drain got=%0d exp=0", count); end
  endtask

  task automatic test_bypass();
    disp_ready = 1'b0;
    set_issue(4'd4, 4'd3, 4'd0, 1'b0, 1'b1, 32'd0, 32'h55);
    cdb_valid = 2'b10; cid1 = 4'd3; cval1 = 32'h12345678;
    tick();
    issue_valid = 1'b0; cdb_valid = 2'b00;
    #1;
    checks++; if (disp_valid !== 1'b1 || disp_vj !== 32'h12345678 || disp_vk !== 32'h55) begin failures++; $display("FAIL bypass got valid=%0b vj=%0h vk=%0h exp 1/12345678/55", disp_valid, disp_vj, disp_vk); end
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL bypass_drain got=%0d exp=0", count); end
  endtask

  task automatic test_flush_stall();
    disp_ready = 1'b0;
    set_issue(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'd1, 32'd1); tick();
    set_issue(4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'd2, 32'd2); tick();
    set_issue(4'd2, 4'd9, 4'd0, 1'b0, 1'b1, 32'd0, 32'd3); tick();
    set_issue(4'd3, 4'd9, 4'd0, 1'b0, 1'b1, 32'd0, 32'd4); tick();
    issue_valid = 1'b0;
    rdy_in = 1'b0; disp_ready = 1'b1;
    cdb_valid = 2'b01; cid0 = 4'd9; cval0 = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (issue_ready !== 1'b0 || disp_valid !== 1'b0 || count !== 4'd4) begin failures++; $display("FAIL stall got ir=%0b dv=%0b count=%0d exp 0/0/4", issue_ready, disp_valid, count); end
      tick();
    end
    rdy_in = 1'b1; cdb_valid = 2'b00; disp_ready = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b1 || disp_dest !== 4'd0) begin failures++; $display("FAIL stall_resume got dv=%0b dest=%0d exp 1/0", disp_valid, disp_dest); end
    disp_ready = 1'b1;
    tick(); tick();
    disp_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd2 || disp_valid !== 1'b0) begin failures++; $display("FAIL stall_lost_cdb got count=%0d dv=%0b exp 2/0", count, disp_valid); end
    clear_in = 1'b1;
    set_issue(4'd5, 4'd0, 4'd0, 1'b1, 1'b1, 32'd5, 32'd5);
    tick();
    clear_in = 1'b0; issue_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || disp_valid !== 1'b0) begin failures++; $display("FAIL flush got count=%0d empty=%0b dv=%0b exp 0/1/0", count, empty, disp_valid); end
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_issue_dropped got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    int sel, best, age;
    bit exp_dv, exp_ir;
    logic [3:0] dst;
    logic [31:0] v;
    ent_t e;
    mq.delete();
    rob_head = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      rdy_in      = ($urandom_range(0, 7) != 0);
      clear_in    = ($urandom_range(0, 59) == 0);
      disp_ready  = ($urandom_range(0, 3) != 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      do dst = 4'($urandom_range(0, 15)); while (tag_in_use(dst));
      issue_dest = dst;
      issue_op   = 6'($urandom);
      issue_qj   = 4'($urandom_range(0, 7));
      issue_qk   = 4'($urandom_range(0, 7));
      issue_rdj  = 1'($urandom_range(0, 1));
      issue_rdk  = 1'($urandom_range(0, 1));
      issue_vj   = $urandom; issue_vk = $urandom; issue_imm = $urandom;
      cdb_valid  = 2'($urandom_range(0, 3));
      cid0 = 4'($urandom_range(0, 7)); cid1 = 4'($urandom_range(0, 7));
      cval0 = $urandom; cval1 = $urandom;
      if ($urandom_range(0, 7) == 0) cid1 = cid0;
      #1;
      sel = -1; best = 99;
      foreach (mq[i]) begin
        if (mq[i].rdj && mq[i].rdk) begin
          age = (int'(mq[i].dest) - int'(rob_head) + 16) % 16;
          if (age < best) begin best = age; sel = i; end
        end
      end
      exp_dv = rdy_in && (sel >= 0);
      exp_ir = rdy_in && (mq.size() < 8);
      checks++; if (int'(count) !== mq.size() || full !== (mq.size() == 8) || empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_count c=%0d got count=%0d full=%0b empty=%0b exp count=%0d", c, count, full, empty, mq.size()); end
      checks++; if (issue_ready !== exp_ir || disp_valid !== exp_dv) begin failures++; $display("FAIL rnd_handshake c=%0d got ir=%0b dv=%0b exp ir=%0b dv=%0b", c, issue_ready, disp_valid, exp_ir, exp_dv); end
      if (exp_dv) begin
        e = mq[sel];
        checks++; if (disp_dest !== e.dest || disp_op !== e.op || disp_vj !== e.vj || disp_vk !== e.vk || disp_imm !== e.imm) begin failures++; $display("FAIL rnd_disp c=%0d got dest=%0d op=%0h vj=%0h vk=%0h imm=%0h exp dest=%0d op=%0h vj=%0h vk=%0h imm=%0h", c, disp_dest, disp_op, disp_vj, disp_vk, disp_imm, e.dest, e.op, e.vj, e.vk, e.imm); end
      end else begin
        checks++; if ({disp_op, disp_vj, disp_vk, disp_imm, disp_dest} !== 106'd0) begin failures++; $display("FAIL rnd_disp_zero c=%0d got dest=%0d vj=%0h exp all zero", c, disp_dest, disp_vj); end
      end
      if (clear_in) begin
        mq.delete();
      end else if (rdy_in) begin
        foreach (mq[i]) begin
          if (!mq[i].rdj && model_cdb(mq[i].qj, v)) begin mq[i].rdj = 1'b1; mq[i].vj = v; end
          if (!mq[i].rdk && model_cdb(mq[i].qk, v)) begin mq[i].rdk = 1'b1; mq[i].vk = v; end
        end
        if (exp_dv && disp_ready) mq.delete(sel);
        if (issue_valid && exp_ir) begin
          e.op = issue_op; e.dest = issue_dest; e.qj = issue_qj; e.qk = issue_qk;
          e.imm = issue_imm; e.rdj = issue_rdj; e.rdk = issue_rdk;
          e.vj = issue_vj; e.vk = issue_vk;
          if (!issue_rdj && model_cdb(issue_qj, v)) begin e.rdj = 1'b1; e.vj = v; end
          if (!issue_rdk && model_cdb(issue_qk, v)) begin e.rdk = 1'b1; e.vk = v; end
          mq.push_back(e);
        end
      end
      tick();
    end
    rdy_in = 1'b1; clear_in = 1'b0; issue_valid = 1'b0; cdb_valid = 2'b00; disp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_reset_mid();
    test_wrap_order();
    test_dual_cdb();
    test_bypass();
    test_flush_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
